// File: rtl/io_write_arbiter_if.sv
// Write-request bus between the CPU, two peripherals and the data-memory write port.
interface io_write_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 13
);
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [15:0]           cpu_din;
    logic                  cpu_stall;

    logic                  p0_valid;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [15:0]           p0_din;
    logic                  p0_ready;

    logic                  p1_valid;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [15:0]           p1_din;
    logic                  p1_ready;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_din;

    // Requester side: drives requests, observes grants and the memory port.
    modport master (
        output cpu_we, cpu_addr, cpu_din,
        output p0_valid, p0_addr, p0_din,
        output p1_valid, p1_addr, p1_din,
        input  cpu_stall, p0_ready, p1_ready,
        input  mem_we, mem_addr, mem_din
    );

    // Arbiter side.
    modport slave (
        input  cpu_we, cpu_addr, cpu_din,
        input  p0_valid, p0_addr, p0_din,
        input  p1_valid, p1_addr, p1_din,
        output cpu_stall, p0_ready, p1_ready,
        output mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/io_write_arbiter.sv
// Data-memory write arbiter: CPU has priority, two peripherals share a
// round-robin slot, winner is registered onto the memory port (1-cycle latency).
// Optional starvation guard enabled by macro IO_WRITE_ARBITER_STARVE_GUARD_EN:
// a peripheral blocked STARVE_LIMIT cycles is forced ahead of the CPU.
module io_write_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    io_write_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_P0   = 2'd2,
        SEL_P1   = 2'd3
    } sel_t;

    // Reject an out-of-range limit at elaboration.
    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("io_write_arbiter: STARVE_LIMIT must be in 1..15");
    end

    sel_t       sel;
    logic       rr;
    logic [1:0] pvalid;
    logic [1:0] starved;

    assign pvalid = {bus.p1_valid, bus.p0_valid};

    // Round-robin pick among the peripherals flagged in mask; rr's choice first.
    function automatic sel_t pick_periph(input logic [1:0] mask, input logic ptr);
        sel_t res;
        res = SEL_NONE;
        if (mask[ptr]) begin
            res = ptr ? SEL_P1 : SEL_P0;
        end else if (mask[~ptr]) begin
            res = ptr ? SEL_P0 : SEL_P1;
        end
        return res;
    endfunction

`ifdef IO_WRITE_ARBITER_STARVE_GUARD_EN
    logic [1:0][CNT_W-1:0] wait_cnt;
    logic [1:0]            grant;

    assign grant = {sel == SEL_P1, sel == SEL_P0};

    // Starved: valid and the blocked-cycle counter has saturated.
    always_comb begin
        starved = 2'b00;
        for (int i = 0; i < 2; i++) begin
            starved[i] = pvalid[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Per-peripheral blocked-cycle counters, saturating at the limit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || !pvalid[i] || grant[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
            end
        end
    end

    // CPU stalls whenever it requests but is not served, including during reset.
    assign bus.cpu_stall = bus.cpu_we && (reset || sel == SEL_P0 || sel == SEL_P1);
`else
    assign starved       = 2'b00;
    assign bus.cpu_stall = 1'b0;
`endif

    // Winner selection from current-cycle requests; nothing wins during reset.
    always_comb begin
        sel = SEL_NONE;
        if (!reset) begin
            if (|starved) begin
                sel = pick_periph(starved, rr);
            end else if (bus.cpu_we) begin
                sel = SEL_CPU;
            end else begin
                sel = pick_periph(pvalid, rr);
            end
        end
    end

    assign bus.p0_ready = (sel == SEL_P0);
    assign bus.p1_ready = (sel == SEL_P1);

    // Memory write port register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            rr           <= 1'b0;
        end else begin
            bus.mem_we <= (sel != SEL_NONE);
            case (sel)
                SEL_CPU: begin
                    bus.mem_addr <= bus.cpu_addr;
                    bus.mem_din  <= bus.cpu_din;
                end
                SEL_P0: begin
                    bus.mem_addr <= bus.p0_addr;
                    bus.mem_din  <= bus.p0_din;
                    rr           <= 1'b1;
                end
                SEL_P1: begin
                    bus.mem_addr <= bus.p1_addr;
                    bus.mem_din  <= bus.p1_din;
                    rr           <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_write_arbiter.sv
// Self-checking bench for io_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Build with or without IO_WRITE_ARBITER_STARVE_GUARD_EN.
module tb_io_write_arbiter;
    localparam int unsigned AW    = 13;
    localparam int unsigned LIMIT = 4;
`ifdef IO_WRITE_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_write_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    io_write_arbiter #(
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            model_on = 1'b0;
    bit            m_rr;
    int            m_wait [2];
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_din;

    // Index of the set flag that the pointer prefers, else the other, else -1.
    function automatic int rr_choice(input bit s0, input bit s1, input bit ptr);
        bit s [2];
        s[0] = s0;
        s[1] = s1;
        if (s[ptr])  return int'(ptr);
        if (s[!ptr]) return int'(!ptr);
        return -1;
    endfunction

    // Check every cycle, then advance the model to the next edge.
    always @(negedge clk) begin : model_check
        bit v  [2];
        bit st [2];
        int win;
        bit exp_stall;
        v[0] = bus.p0_valid;
        v[1] = bus.p1_valid;
        win  = -1;
        if (!reset) begin
            for (int i = 0; i < 2; i++) st[i] = GUARD && v[i] && (m_wait[i] >= LIMIT);
            if (st[0] || st[1])  win = rr_choice(st[0], st[1], m_rr);
            else if (bus.cpu_we) win = 2;
            else                 win = rr_choice(v[0], v[1], m_rr);
        end
        exp_stall = GUARD && bus.cpu_we && (reset || win == 0 || win == 1);
        if (model_on) begin
            chk("m_p0_ready", 32'(bus.p0_ready), 32'(win == 0));
            chk("m_p1_ready", 32'(bus.p1_ready), 32'(win == 1));
            chk("m_cpu_stall", 32'(bus.cpu_stall), 32'(exp_stall));
            chk("m_mem_we", 32'(bus.mem_we), 32'(m_we));
            chk("m_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk("m_mem_din", 32'(bus.mem_din), 32'(m_din));
        end
        if (reset) begin
            model_on  = 1'b1;
            m_we      = 1'b0;
            m_addr    = '0;
            m_din     = '0;
            m_rr      = 1'b0;
            m_wait[0] = 0;
            m_wait[1] = 0;
        end else begin
            m_we = (win >= 0);
            if (win == 2) begin
                m_addr = bus.cpu_addr; m_din = bus.cpu_din;
            end else if (win == 0) begin
                m_addr = bus.p0_addr;  m_din = bus.p0_din;
            end else if (win == 1) begin
                m_addr = bus.p1_addr;  m_din = bus.p1_din;
            end
            if (win == 0 || win == 1) m_rr = (win == 0);
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || win == i)     m_wait[i] = 0;
                else if (m_wait[i] < LIMIT) m_wait[i]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit cwe, input int ca, input int cd,
                          input bit v0, input int a0, input int d0,
                          input bit v1, input int a1, input int d1);
        bus.cpu_we   = cwe; bus.cpu_addr = AW'(ca); bus.cpu_din = 16'(cd);
        bus.p0_valid = v0;  bus.p0_addr  = AW'(a0); bus.p0_din  = 16'(d0);
        bus.p1_valid = v1;  bus.p1_addr  = AW'(a1); bus.p1_din  = 16'(d1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        bit prev_v0, prev_v1, g0, g1;
        reset = 1'b1;
        set_in(1, 5, 5, 1, 6, 6, 0, 0, 0);
        next_cycle();
        next_cycle();
        #2;
        // Reset state and grant suppression.
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rst_p0_ready", 32'(bus.p0_ready), 32'd0);
`ifdef IO_WRITE_ARBITER_STARVE_GUARD_EN
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd1);
`else
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
`endif
        next_cycle();

        // Single peripheral streaming at full rate.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 1, 7802, 'hFFFF, 0, 0, 0);
            #2;
            chk("p0only_ready", 32'(bus.p0_ready), 32'd1);
            if (i >= 1) begin
                chk("p0only_we", 32'(bus.mem_we), 32'd1);
                chk("p0only_addr", 32'(bus.mem_addr), 32'd7802);
                chk("p0only_din", 32'(bus.mem_din), 32'hFFFF);
            end
            next_cycle();
        end

        // Both peripherals, CPU idle: strict alternation starting with p0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 1, 'h111, 'hA0A0, 1, 'h222, 'hB0B0);
            #2;
            chk("alt_p0_ready", 32'(bus.p0_ready), 32'(i % 2 == 0));
            chk("alt_p1_ready", 32'(bus.p1_ready), 32'(i % 2 == 1));
            if (i >= 1) chk("alt_addr", 32'(bus.mem_addr), ((i - 1) % 2 == 0) ? 32'h111 : 32'h222);
            next_cycle();
        end

        // CPU and p0 both held.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 100, 'h1234, 1, 55, 'hBEEF, 0, 0, 0);
            #2;
`ifdef IO_WRITE_ARBITER_STARVE_GUARD_EN
            chk("cpu_p0_ready", 32'(bus.p0_ready), 32'(i == 4));
            chk("cpu_p0_stall", 32'(bus.cpu_stall), 32'(i == 4));
            if (i >= 1) chk("cpu_p0_addr", 32'(bus.mem_addr), (i == 5) ? 32'd55 : 32'd100);
`else
            chk("cpu_p0_ready", 32'(bus.p0_ready), 32'd0);
            chk("cpu_p0_stall", 32'(bus.cpu_stall), 32'd0);
            if (i >= 1) begin
                chk("cpu_p0_we", 32'(bus.mem_we), 32'd1);
                chk("cpu_p0_addr", 32'(bus.mem_addr), 32'd100);
            end
`endif
            next_cycle();
        end

        // Both starved under continuous CPU writes with rr pointing at p1.
        do_reset();
        set_in(0, 0, 0, 1, 'h10, 1, 0, 0, 0);
        #2;
        chk("dual_setup_p0", 32'(bus.p0_ready), 32'd1);
        next_cycle();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 100, 'h1234, 1, 'h10, 1, 1, 'h20, 2);
            #2;
`ifdef IO_WRITE_ARBITER_STARVE_GUARD_EN
            chk("dual_p1_ready", 32'(bus.p1_ready), 32'(i == 4));
            chk("dual_p0_ready", 32'(bus.p0_ready), 32'(i == 5));
            chk("dual_stall", 32'(bus.cpu_stall), 32'(i == 4 || i == 5));
`else
            chk("dual_p1_ready", 32'(bus.p1_ready), 32'd0);
            chk("dual_p0_ready", 32'(bus.p0_ready), 32'd0);
            chk("dual_stall", 32'(bus.cpu_stall), 32'd0);
`endif
            next_cycle();
        end

        // Reset during a pending p1 grant clears the write, rr and counters.
        do_reset();
        set_in(0, 0, 0, 1, 'h10, 1, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 100, 'h1234, 0, 0, 0, 1, 'h30, 'h3333);
            next_cycle();
        end
        reset = 1'b1;
        set_in(1, 100, 'h1234, 0, 0, 0, 1, 'h30, 'h3333);
        #2;
        chk("rstg_p1_ready", 32'(bus.p1_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        set_in(0, 0, 0, 1, 'h40, 4, 1, 'h30, 'h3333);
        #2;
        chk("rstg_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rstg_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstg_rr_p0", 32'(bus.p0_ready), 32'd1);
        next_cycle();
        for (int i = 1; i < 5; i++) begin
            set_in(1, 100, 'h1234, 0, 0, 0, 1, 'h30, 'h3333);
            #2;
`ifdef IO_WRITE_ARBITER_STARVE_GUARD_EN
            chk("rstg_cnt_p1", 32'(bus.p1_ready), 32'(i == 4));
`else
            chk("rstg_cnt_p1", 32'(bus.p1_ready), 32'd0);
`endif
            next_cycle();
        end

        // Randomized traffic; blocked peripherals tend to keep requesting.
        prev_v0 = 1'b0; prev_v1 = 1'b0; g0 = 1'b0; g1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit v0, v1;
            reset = ($urandom_range(0, 99) < 2);
            v0 = (prev_v0 && !g0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 50);
            v1 = (prev_v1 && !g1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 50);
            set_in($urandom_range(0, 99) < 70, int'($urandom), int'($urandom),
                   v0, int'($urandom), int'($urandom), v1, int'($urandom), int'($urandom));
            #2;
            g0 = bus.p0_ready;
            g1 = bus.p1_ready;
            prev_v0 = v0;
            prev_v1 = v1;
            next_cycle();
        end

        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/io_write_arbiter.md
IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, the data-memory address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of blocked cycles before a peripheral request is forced; legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports cpu_we  input  1, cpu_addr  input  ADDR_WIDTH, and cpu_din  input  16; these are the CPU write request.
REQ-006 SHALL have port cpu_stall  output  1  CPU write refused this cycle; the CPU holds its request.
REQ-007 SHALL have ports p0_valid  input  1, p0_addr  input  ADDR_WIDTH, p0_din  input  16, and p0_ready  output  1; this is peripheral 0 (button copy engine).
REQ-008 SHALL have ports p1_valid  input  1, p1_addr  input  ADDR_WIDTH, p1_din  input  16, and p1_ready  output  1; this is peripheral 1.
REQ-009 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_WIDTH, and mem_din  output  16; these are the registered data-memory write port.

Function
REQ-010 SHALL select at most one winner per cycle from cpu_we, p0_valid and p1_valid, using current-cycle inputs combinationally.
REQ-011 SHALL make the CPU win whenever cpu_we=1 and no starvation override is active (REQ-016).
REQ-012 SHALL arbitrate peripherals without a CPU winner by a 1-bit round-robin pointer rr: the peripheral rr points to wins if it is valid; otherwise the other one wins if it is valid.
REQ-013 SHALL set rr to point at the other peripheral after each peripheral grant, and leave it unchanged otherwise.
REQ-014 SHALL assert pN_ready combinationally only in a cycle where peripheral N is the winner; a transfer occurs when pN_valid and pN_ready are both 1.
REQ-015 SHALL keep a per-peripheral wait counter: +1 on each valid-and-not-ready cycle, saturating at STARVE_LIMIT; cleared on a grant or when valid=0.
REQ-016 SHALL treat a peripheral as starved when its counter equals STARVE_LIMIT and valid=1; a starved peripheral beats the CPU; if both are starved, rr decides.
REQ-017 SHALL assert cpu_stall = cpu_we AND (a peripheral wins this cycle); cpu_stall SHALL be 0 when cpu_we=0.
REQ-018 SHALL register the winner's address and data into mem_addr and mem_din and set mem_we=1 on the next edge, giving 1-cycle latency; with no winner, mem_we=0 and mem_addr/mem_din hold their values.
REQ-019 SHALL sustain back-to-back grants with no bubble cycles: full throughput of 1 write per cycle.
REQ-020 SHALL not check for identical addresses across requesters; ordering follows grant order only.

Reset
REQ-021 SHALL on reset set mem_we=0, mem_addr=0, mem_din=0, rr=0 (p0 preferred), and both counters=0.
REQ-022 SHALL suppress all grants while reset=1: p0_ready=p1_ready=0 and cpu_stall=cpu_we.
REQ-023 SHALL drop a write that is registered in the same cycle reset is asserted, so mem_we=0 on the following cycle.

Configuration
REQ-024 SHALL implement the starvation guard (REQ-015/016) only when macro IO_WRITE_ARBITER_STARVE_GUARD_EN is defined.
REQ-025 SHALL, without IO_WRITE_ARBITER_STARVE_GUARD_EN: remove the counters, make the CPU always win when cpu_we=1, and tie cpu_stall to 0.

Verification
REQ-026 SHALL cover: only p0_valid=1, addr 7802, din 16'hFFFF, for 6 cycles -> p0_ready=1 each cycle; mem_we=1 from cycle 1 with addr 7802, din FFFF.
REQ-027 SHALL cover: p0_valid=p1_valid=1 continuously with the CPU idle -> grants alternate p0,p1,p0,p1 starting with p0 after reset.
REQ-028 SHALL cover: cpu_we=1 (addr 100, din 1234) and p0_valid=1 both held, with guard on -> CPU wins cycles 0-3; cycle 4 p0 wins and cpu_stall=1; cycle 5 CPU wins again.
REQ-029 SHALL cover: the same stimulus as REQ-028 with the macro undefined -> p0_ready stays 0 throughout, mem_we=1 with addr 100 every cycle, and cpu_stall=0.
REQ-030 SHALL cover: both peripherals starved under a continuous CPU write with rr=1 -> p1 is granted first, then p0 in the next cycle, with cpu_stall=1 in both cycles.
REQ-031 SHALL cover: reset asserted in the cycle of a p1 grant -> mem_we=0 next cycle, rr=0, and counters=0.
